data_mem_responder: RTL and testbench

- Responder end of the pipeline's data-memory request interface.
- Accepts the MEM-stage request (ena_data, data_rw, addr, data_in) and serves it from an internal word array after a programmable access latency.
- While a request is outstanding it raises busy so the IF/ID/EX stages hold. It then returns read data with a one-cycle ready pulse.
- Sits where the single-cycle data memory sits today. The counter output feeds the EX/MEM count input.

---
 rtl/data_mem_responder_if.sv | 37 +++
 rtl/data_mem_responder.sv | 97 +++++++++
 tb/tb_data_mem_responder.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: MEM-stage data request/response bundle.
// master = pipeline MEM stage, slave = memory responder.
interface data_mem_responder_if;
  logic        ena_data;
  logic        data_rw;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ready;
  logic        busy;
  logic        err;
  logic [3:0]  count;

  modport master (
    output ena_data,
    output data_rw,
    output addr,
    output data_in,
    input  data_out,
    input  ready,
    input  busy,
    input  err,
    input  count
  );

  modport slave (
    input  ena_data,
    input  data_rw,
    input  addr,
    input  data_in,
    output data_out,
    output ready,
    output busy,
    output err,
    output count
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory with busy stall,
// one-cycle ready pulse, sticky range error and latency counter.
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0] mem [DEPTH];

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rw_q;
  logic [3:0]  count_q;
  logic [31:0] data_q;
  logic        ready_q;
  logic        err_q;

  logic          accept;
  logic          access;
  logic          oor;
  logic [AW-1:0] idx;

  assign idx    = addr_q[AW-1:0];
  assign oor    = |addr_q[31:AW];
  assign accept = (state == S_IDLE) && bus.ena_data;
  assign access = (state == S_WAIT) && (count_q == 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == S_IDLE): if (bus.ena_data) state_nx = S_WAIT;
      (state == S_WAIT): if (count_q == 4'd1) state_nx = S_RESP;
      (state == S_RESP): state_nx = S_IDLE;
      default:           state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      count_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= access;
      if (accept) begin
        addr_q  <= bus.addr;
        rw_q    <= bus.data_rw;
        wdata_q <= bus.data_in;
        count_q <= 4'(WAIT_CYCLES);
      end else if (access) begin
        count_q <= '0;
      end else if (state == S_WAIT) begin
        count_q <= count_q - 4'd1;
      end
      if (access) begin
        if (oor) err_q <= 1'b1;
        if (!rw_q) data_q <= oor ? '0 : mem[idx];
      end
    end
  end

  // State is forced to IDLE by reset, so an aborted
  // write can never reach its access edge.
  always_ff @(posedge clk) begin
    if (access && rw_q && !oor) mem[idx] <= wdata_q;
  end

  assign bus.data_out = data_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = accept || (state == S_WAIT);
  assign bus.err      = err_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of data_mem_responder
// at WAIT_CYCLES 2 (main), 1 and 15 (latency sweep).
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   clk_run = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 if (clk_run) clk = ~clk;

  data_mem_responder_if b2 ();
  data_mem_responder_if b1 ();
  data_mem_responder_if b15 ();

  data_mem_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bus(b2)
  );
  data_mem_responder #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  data_mem_responder #(.WAIT_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .bus(b15)
  );

  task automatic req(
    input  logic        rw,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output int          lat,
    output logic [31:0] dout
  );
    b2.ena_data = 1'b1;
    b2.data_rw  = rw;
    b2.addr     = a;
    b2.data_in  = d;
    @(posedge clk); #1;
    b2.ena_data = 1'b0;
    lat  = -1;
    dout = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (b2.ready === 1'b1) begin
        lat  = n;
        dout = b2.data_out;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (b2.data_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_data got %h exp 0", b2.data_out);
    end
    checks++;
    if ({b2.ready, b2.busy, b2.err} !== 3'b000) begin
      errors++;
      $display("FAIL rst_flags got %b exp 000",
               {b2.ready, b2.busy, b2.err});
    end
    checks++;
    if (b2.count !== 4'd0) begin
      errors++;
      $display("FAIL rst_count got %0d exp 0", b2.count);
    end
    clk_run = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({b2.ready, b2.busy, b2.err, b2.count, b2.data_out}
          !== 39'h0) begin
        errors++;
        $display("FAIL idle_hold r%b b%b e%b c%0d d%h exp all 0",
                 b2.ready, b2.busy, b2.err, b2.count, b2.data_out);
      end
    end
  endtask

  task automatic test_write_read;
    int          lat;
    logic [31:0] d;
    b2.ena_data = 1'b1;
    b2.data_rw  = 1'b1;
    b2.addr     = 32'd5;
    b2.data_in  = 32'hDEADBEEF;
    #1;
    checks++;
    if (b2.busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_busy_e0 got %b exp 1", b2.busy);
    end
    @(posedge clk); #1;
    b2.ena_data = 1'b0;
    checks++;
    if (b2.count !== 4'd2 || b2.busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_e0 count %0d busy %b exp 2 1",
               b2.count, b2.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (b2.count !== 4'd1 || b2.ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_e1 count %0d ready %b exp 1 0",
               b2.count, b2.ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({b2.ready, b2.busy, b2.count} !== 6'b10_0000) begin
      errors++;
      $display("FAIL wr_e2 r%b b%b c%0d exp r1 b0 c0",
               b2.ready, b2.busy, b2.count);
    end
    checks++;
    if (b2.data_out !== 32'h0) begin
      errors++;
      $display("FAIL wr_data_out got %h exp 0", b2.data_out);
    end
    @(posedge clk); #1;
    checks++;
    if (b2.ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_ready_drop got %b exp 0", b2.ready);
    end
    req(1'b0, 32'd5, 32'h0, lat, d);
    checks++;
    if (lat !== 2 || d !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd5 lat %0d data %h exp 2 deadbeef", lat, d);
    end
    req(1'b1, 32'd7, 32'h77777777, lat, d);
    req(1'b1, 32'd3, 32'h33333333, lat, d);
    req(1'b1, 32'd9, 32'h99990000, lat, d);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL wr9_lat got %0d exp 2", lat);
    end
  endtask

  task automatic test_held_inputs;
    b2.ena_data = 1'b1;
    b2.data_rw  = 1'b0;
    b2.addr     = 32'd5;
    @(posedge clk); #1;
    b2.addr = 32'd7;
    @(posedge clk); #1;
    checks++;
    if (b2.count !== 4'd1 || b2.busy !== 1'b1) begin
      errors++;
      $display("FAIL held_e1 count %0d busy %b exp 1 1",
               b2.count, b2.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (b2.ready !== 1'b1 || b2.data_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL held_resp r%b d%h exp 1 deadbeef",
               b2.ready, b2.data_out);
    end
    checks++;
    if (b2.busy !== 1'b0) begin
      errors++;
      $display("FAIL held_resp_busy got %b exp 0", b2.busy);
    end
    @(posedge clk); #1;
    checks++;
    if ({b2.ready, b2.busy, b2.count} !== 6'b01_0000) begin
      errors++;
      $display("FAIL held_idle r%b b%b c%0d exp r0 b1 c0",
               b2.ready, b2.busy, b2.count);
    end
    @(posedge clk); #1;
    b2.ena_data = 1'b0;
    checks++;
    if (b2.count !== 4'd2) begin
      errors++;
      $display("FAIL held_reaccept count %0d exp 2", b2.count);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (b2.ready !== 1'b1 || b2.data_out !== 32'h77777777) begin
      errors++;
      $display("FAIL held_rd7 r%b d%h exp 1 77777777",
               b2.ready, b2.data_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range;
    int          lat;
    logic [31:0] d;
    req(1'b0, 32'h0000_0400, 32'h0, lat, d);
    checks++;
    if (lat !== 2 || d !== 32'h0) begin
      errors++;
      $display("FAIL oor_rd lat %0d data %h exp 2 0", lat, d);
    end
    checks++;
    if (b2.err !== 1'b1) begin
      errors++;
      $display("FAIL oor_err got %b exp 1", b2.err);
    end
    req(1'b1, 32'h0010_0003, 32'h00000BAD, lat, d);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL oor_wr_lat got %0d exp 2", lat);
    end
    req(1'b0, 32'd3, 32'h0, lat, d);
    checks++;
    if (d !== 32'h33333333) begin
      errors++;
      $display("FAIL oor_mem3 got %h exp 33333333", d);
    end
    checks++;
    if (b2.err !== 1'b1) begin
      errors++;
      $display("FAIL oor_sticky got %b exp 1", b2.err);
    end
  endtask

  task automatic test_reset_mid_wait;
    int          lat;
    logic [31:0] d;
    b2.ena_data = 1'b1;
    b2.data_rw  = 1'b1;
    b2.addr     = 32'd9;
    b2.data_in  = 32'h1234;
    @(posedge clk); #1;
    b2.ena_data = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b2.count !== 4'd1) begin
      errors++;
      $display("FAIL mid_e1 count %0d exp 1", b2.count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({b2.ready, b2.busy, b2.err, b2.count} !== 7'h0) begin
      errors++;
      $display("FAIL mid_rst r%b b%b e%b c%0d exp all 0",
               b2.ready, b2.busy, b2.err, b2.count);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (b2.ready !== 1'b0 || b2.busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_quiet r%b b%b exp 0 0",
                 b2.ready, b2.busy);
      end
    end
    req(1'b0, 32'd9, 32'h0, lat, d);
    checks++;
    if (d !== 32'h99990000) begin
      errors++;
      $display("FAIL mid_rd9 got %h exp 99990000", d);
    end
  endtask

  task automatic test_latency;
    int c1;
    int c15;
    b1.ena_data  = 1'b1;
    b1.data_rw   = 1'b1;
    b1.addr      = 32'd1;
    b1.data_in   = 32'd1;
    b15.ena_data = 1'b1;
    b15.data_rw  = 1'b1;
    b15.addr     = 32'd1;
    b15.data_in  = 32'd1;
    @(posedge clk); #1;
    b1.ena_data  = 1'b0;
    b15.ena_data = 1'b0;
    checks++;
    if (b1.count !== 4'd1 || b15.count !== 4'd15) begin
      errors++;
      $display("FAIL lat_start c1 %0d c15 %0d exp 1 15",
               b1.count, b15.count);
    end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      c1  = (k < 1) ? 1 - k : 0;
      c15 = (k < 15) ? 15 - k : 0;
      checks++;
      if (b1.ready !== (k == 1) || b1.count !== 4'(c1)) begin
        errors++;
        $display("FAIL lat1 k%0d r%b c%0d exp r%0d c%0d",
                 k, b1.ready, b1.count, k == 1, c1);
      end
      checks++;
      if (b15.ready !== (k == 15) || b15.count !== 4'(c15)
          || b15.busy !== (k < 15)) begin
        errors++;
        $display("FAIL lat15 k%0d r%b c%0d b%b exp r%0d c%0d b%0d",
                 k, b15.ready, b15.count, b15.busy,
                 k == 15, c15, k < 15);
      end
    end
  endtask

  initial begin
    b2.ena_data  = 1'b0;
    b2.data_rw   = 1'b0;
    b2.addr      = '0;
    b2.data_in   = '0;
    b1.ena_data  = 1'b0;
    b1.data_rw   = 1'b0;
    b1.addr      = '0;
    b1.data_in   = '0;
    b15.ena_data = 1'b0;
    b15.data_rw  = 1'b0;
    b15.addr     = '0;
    b15.data_in  = '0;
    test_reset();
    test_write_read();
    test_held_inputs();
    test_out_of_range();
    test_reset_mid_wait();
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
